// File: rtl/irq_ctrl_if.sv
// Register-window bus between the 6502 glue logic and the interrupt controller.
// The master drives select, direction, strobe, address and write data; the slave returns read data.
interface irq_ctrl_if;
    logic       cs_n;
    logic       rw;
    logic       strobe;
    logic [3:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cs_n, rw, strobe, reg_addr, wdata, input rdata);
    modport slave  (input cs_n, rw, strobe, reg_addr, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised IRQ lines, per-channel level/edge pending latches,
// enable mask, priority vector with auto-acknowledge and a registered active-low IRQB.
module irq_ctrl #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irq_in_n,
    irq_ctrl_if.slave           bus,
    output logic                irq_n
);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0] s_dly_q, s_dly_d;
    logic [CHANNELS-1:0] enable_q, enable_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic                irq_n_q, irq_n_d;

    logic [CHANNELS-1:0] s, fall, active, clr, mode_chg;
    logic [15:0]         st16, en16, pd16, md16;
    logic [3:0]          vec_idx;
    logic                vec_valid, wr_en, rd_en, ack;
    logic [7:0]          rdata_c;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        active    = pending_q & enable_q;
        vec_valid = |active;
        vec_idx   = 4'd0;
        // Scan from the top so the lowest-numbered active channel wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 4'(i);
        end

        wr_en = bus.strobe & ~bus.cs_n & ~bus.rw;
        rd_en = ~bus.cs_n & bus.rw;
        ack   = bus.strobe & rd_en & (bus.reg_addr == 4'd8) & vec_valid;

        sync_d[0] = irq_in_n;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        s_dly_d = s;
        fall    = s_dly_q & ~s;

        enable_d = enable_q;
        mode_d   = mode_q;
        clr      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && bus.reg_addr[0] == (i >= 8)) begin
                case (bus.reg_addr[3:1])
                    3'd1:    enable_d[i] = bus.wdata[i % 8];
                    3'd2:    clr[i]      = bus.wdata[i % 8];
                    3'd3:    mode_d[i]   = bus.wdata[i % 8];
                    default: ;
                endcase
            end
            if (ack && vec_idx == 4'(i)) clr[i] = 1'b1;
        end

        // A mode change drops the latch; edge channels keep a new edge over any clear.
        mode_chg  = mode_d ^ mode_q;
        pending_d = ~mode_chg & ((~mode_q & ~s) |
                                 (mode_q & (fall | (pending_q & ~clr))));
        irq_n_d   = ~vec_valid;
    end

    always_comb begin
        st16    = 16'(active);
        en16    = 16'(enable_q);
        pd16    = 16'(pending_q);
        md16    = 16'(mode_q);
        rdata_c = 8'h00;
        if (rd_en) begin
            case (bus.reg_addr)
                4'd0:    rdata_c = st16[7:0];
                4'd1:    rdata_c = st16[15:8];
                4'd2:    rdata_c = en16[7:0];
                4'd3:    rdata_c = en16[15:8];
                4'd4:    rdata_c = pd16[7:0];
                4'd5:    rdata_c = pd16[15:8];
                4'd6:    rdata_c = md16[7:0];
                4'd7:    rdata_c = md16[15:8];
                4'd8:    rdata_c = vec_valid ? {1'b1, 3'b000, vec_idx} : 8'h00;
                default: rdata_c = 8'h00;
            endcase
        end
    end

    assign bus.rdata = rdata_c;
    assign irq_n     = irq_n_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            s_dly_q   <= '1;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_n_q   <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            s_dly_q   <= s_dly_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            irq_n_q   <= irq_n_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with 12 channels and a 2-stage synchroniser.
module tb_irq_ctrl;
    localparam int CH = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] irq_in_n;
    logic          irq_n;
    int            n_checks = 0;
    int            n_errors = 0;

    irq_ctrl_if bus();

    irq_ctrl #(.CHANNELS(CH), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .irq_in_n (irq_in_n),
        .bus      (bus),
        .irq_n    (irq_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cs_n = 1'b1; bus.rw = 1'b1; bus.strobe = 1'b0;
        bus.reg_addr = 4'd0; bus.wdata = 8'h00;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.cs_n = 1'b0; bus.rw = 1'b0; bus.strobe = 1'b1;
        bus.reg_addr = a; bus.wdata = d;
        @(negedge clock);
        idle_bus();
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic stb, input logic [7:0] exp);
        @(negedge clock);
        bus.cs_n = 1'b0; bus.rw = 1'b1; bus.strobe = stb; bus.reg_addr = a;
        #1 check(tag, bus.rdata, exp);
        @(negedge clock);
        idle_bus();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        idle_bus();
        irq_in_n = '1;
        reset    = 1'b1;
        wait_cyc(3);
        reset = 1'b0;

        // Reset state
        wait_cyc(1);
        check("reset_irq_n", {7'd0, irq_n}, 8'h01);
        for (int a = 0; a < 16; a++) rd($sformatf("reset_reg%0d", a), 4'(a), 1'b0, 8'h00);

        // Level latency: assert and release, irq_n follows at edge 4
        wr(4'd2, 8'h01);
        wr(4'd6, 8'h00);
        @(negedge clock); irq_in_n[0] = 1'b0;
        wait_cyc(3);
        check("lvl_edge3", {7'd0, irq_n}, 8'h01);
        wait_cyc(1);
        check("lvl_edge4", {7'd0, irq_n}, 8'h00);
        rd("lvl_status", 4'd0, 1'b0, 8'h01);
        @(negedge clock); irq_in_n[0] = 1'b1;
        wait_cyc(3);
        check("lvl_rel_edge3", {7'd0, irq_n}, 8'h00);
        wait_cyc(1);
        check("lvl_rel_edge4", {7'd0, irq_n}, 8'h01);

        // Edge latch on ch2, then write-1-clear
        wr(4'd6, 8'h04);
        wr(4'd2, 8'h04);
        @(negedge clock); irq_in_n[2] = 1'b0;
        @(negedge clock); irq_in_n[2] = 1'b1;
        wait_cyc(5);
        check("edge_irq_n", {7'd0, irq_n}, 8'h00);
        rd("edge_pending", 4'd4, 1'b0, 8'h04);
        wr(4'd4, 8'h04);
        check("w1c_same_edge", {7'd0, irq_n}, 8'h00);
        wait_cyc(1);
        check("w1c_next_edge", {7'd0, irq_n}, 8'h01);
        rd("w1c_pending", 4'd4, 1'b0, 8'h00);

        // Priority and auto-acknowledge: ch1 and ch5 edge-pending
        wr(4'd6, 8'h22);
        wr(4'd2, 8'h22);
        @(negedge clock); irq_in_n[1] = 1'b0; irq_in_n[5] = 1'b0;
        @(negedge clock); irq_in_n[1] = 1'b1; irq_in_n[5] = 1'b1;
        wait_cyc(5);
        check("prio_irq_n", {7'd0, irq_n}, 8'h00);
        rd("vec_first", 4'd8, 1'b1, 8'h81);
        rd("vec_after_ack", 4'd4, 1'b0, 8'h20);
        rd("vec_second", 4'd8, 1'b1, 8'h85);
        rd("vec_third", 4'd8, 1'b1, 8'h00);
        check("vec_irq_n", {7'd0, irq_n}, 8'h01);

        // Mask: ch3 level-asserted but disabled
        wr(4'd6, 8'h00);
        wr(4'd2, 8'h00);
        @(negedge clock); irq_in_n[3] = 1'b0;
        wait_cyc(5);
        rd("mask_status", 4'd0, 1'b0, 8'h00);
        rd("mask_pending", 4'd4, 1'b0, 8'h08);
        rd("mask_vector", 4'd8, 1'b0, 8'h00);
        check("mask_irq_n", {7'd0, irq_n}, 8'h01);
        @(negedge clock); irq_in_n[3] = 1'b1;
        wait_cyc(5);

        // Upper bank: ch11 and ENABLE_H truncation
        @(negedge clock); irq_in_n[11] = 1'b0;
        wr(4'd3, 8'h08);
        wait_cyc(5);
        rd("hi_pending", 4'd5, 1'b0, 8'h08);
        rd("hi_status", 4'd1, 1'b0, 8'h08);
        rd("hi_vector", 4'd8, 1'b0, 8'h8B);
        check("hi_irq_n", {7'd0, irq_n}, 8'h00);
        wr(4'd3, 8'hFF);
        rd("hi_enable_rb", 4'd3, 1'b0, 8'h0F);
        rd("reserved_9", 4'd9, 1'b0, 8'h00);
        @(negedge clock); irq_in_n[11] = 1'b1;
        wr(4'd3, 8'h00);
        wait_cyc(5);

        // Edge set and W1C in the same cycle on ch4: set wins
        wr(4'd6, 8'h10);
        wr(4'd2, 8'h10);
        @(negedge clock); irq_in_n[4] = 1'b0;
        @(negedge clock); irq_in_n[4] = 1'b1;
        wr(4'd4, 8'h10);
        rd("same_cycle_pending", 4'd4, 1'b0, 8'h10);
        wait_cyc(1);
        check("same_cycle_irq_n", {7'd0, irq_n}, 8'h00);

        // Asynchronous reset mid-pending
        @(negedge clock); reset = 1'b1;
        #1 check("rst_async_irq_n", {7'd0, irq_n}, 8'h01);
        @(negedge clock); reset = 1'b0;
        rd("rst_pending", 4'd4, 1'b0, 8'h00);
        rd("rst_enable", 4'd2, 1'b0, 8'h00);
        rd("rst_mode", 4'd6, 1'b0, 8'h00);
        check("rst_irq_n", {7'd0, irq_n}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
